// File: rtl/r_exec_ctrl.sv
// r_exec_ctrl: multi-cycle controller for R-format ALU instructions.
// It accepts one instruction, reads its two source registers, runs the ALU
// and writes the result back. The sequence is IDLE -> DECODE -> EXEC -> WB,
// so a new instruction can be accepted every 4 cycles.
//
// Ports:
//   clk, reset             sole clock; synchronous active-high reset
//   instr_valid/ready      instruction handshake (ready only in IDLE)
//   instr                  opcode[31:26] rs[25:21] rt[20:16] rd[15:11] funct[5:0]
//   rf_raddr1/2, rf_rdata1/2  register-file read (rs, rt); data is combinational
//   ALUop, alu_a, alu_b    ALU request, registered, meaningful in EXEC
//   alu_result, alu_zero   ALU response, captured at the end of EXEC
//   rf_we, rf_waddr, rf_wdata  write-back, rf_we only in WB
//   done                   one-cycle completion pulse in WB
//   zero_flag, illegal     status of the completed instruction, held until next done
module r_exec_ctrl #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    input  logic [31:0]       instr,
    output logic              instr_ready,
    output logic [4:0]        rf_raddr1,
    output logic [4:0]        rf_raddr2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    output logic [2:0]        ALUop,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              done,
    output logic              zero_flag,
    output logic              illegal
);

    typedef enum logic [1:0] {StIdle, StDecode, StExec, StWb} state_e;

    state_e state_q, state_d;

    // Fields of the accepted instruction still needed after IDLE.
    logic [5:0] opcode_q;
    logic [5:0] funct_q;
    logic [4:0] rd_q;

    logic [4:0]        raddr1_q, raddr2_q;
    logic [2:0]        aluop_q;
    logic [DATA_W-1:0] op1_q, op2_q;
    logic              ill_dec_q;
    logic [4:0]        waddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q, done_q, zero_q, ill_q;

    logic [2:0] dec_aluop;
    logic       dec_illegal;

    // The shamt field is irrelevant to the supported operations.
    logic unused_shamt;
    assign unused_shamt = ^instr[10:6];

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (instr_valid) state_d = StDecode;
            StDecode: state_d = StExec;
            StExec:   state_d = StWb;
            StWb:     state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // funct decode; an illegal instruction still runs as an ADD but never writes.
    always_comb begin
        dec_aluop   = 3'b000;
        dec_illegal = 1'b0;
        case (funct_q)
            6'h20:   dec_aluop = 3'b000;
            6'h22:   dec_aluop = 3'b001;
            6'h24:   dec_aluop = 3'b010;
            6'h25:   dec_aluop = 3'b011;
            6'h2A:   dec_aluop = 3'b100;
            default: dec_illegal = 1'b1;
        endcase
        if (opcode_q != 6'd0) begin
            dec_aluop   = 3'b000;
            dec_illegal = 1'b1;
        end
    end

    // Datapath registers, each loaded in exactly one state.
    always_ff @(posedge clk) begin
        if (reset) begin
            opcode_q  <= '0;
            funct_q   <= '0;
            rd_q      <= '0;
            raddr1_q  <= '0;
            raddr2_q  <= '0;
            aluop_q   <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            ill_dec_q <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            done_q    <= 1'b0;
            zero_q    <= 1'b0;
            ill_q     <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (instr_valid) begin
                        opcode_q <= instr[31:26];
                        raddr1_q <= instr[25:21];
                        raddr2_q <= instr[20:16];
                        rd_q     <= instr[15:11];
                        funct_q  <= instr[5:0];
                    end
                end
                StDecode: begin
                    aluop_q   <= dec_aluop;
                    op1_q     <= rf_rdata1;
                    op2_q     <= rf_rdata2;
                    ill_dec_q <= dec_illegal;
                end
                StExec: begin
                    waddr_q <= rd_q;
                    wdata_q <= alu_result;
                    zero_q  <= alu_zero;
                    ill_q   <= ill_dec_q;
                    done_q  <= 1'b1;
                    we_q    <= !ill_dec_q && (rd_q != 5'd0);
                end
                default: ;
            endcase
        end
    end

    assign instr_ready = (state_q == StIdle);
    assign rf_raddr1   = raddr1_q;
    assign rf_raddr2   = raddr2_q;
    assign ALUop       = aluop_q;
    assign alu_a       = op1_q;
    assign alu_b       = op2_q;
    assign rf_waddr    = waddr_q;
    assign rf_wdata    = wdata_q;
    assign zero_flag   = zero_q;
    assign illegal     = ill_q;
    // A reset raised during WB suppresses the write and the completion pulse.
    assign rf_we       = we_q & ~reset;
    assign done        = done_q & ~reset;

endmodule
